fact_accel: RTL and testbench

FACT_ACCEL -- requirements
Module: fact_accel

---
 rtl/fact_pkg.sv | 19 +
 rtl/fact_dp.sv | 40 ++++
 rtl/fact_accel.sv | 99 +++++++++
 tb/tb_fact_accel.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/fact_pkg.sv
// Shared definitions for the factorial accelerator: register map, FSM encoding
// and operand limits.
package fact_pkg;

  localparam int DATA_W    = 32;
  localparam int N_W       = 4;
  localparam int DEF_MAX_N = 12;

  localparam logic [1:0] N_OFS    = 2'd0;
  localparam logic [1:0] GO_OFS   = 2'd1;
  localparam logic [1:0] STAT_OFS = 2'd2;
  localparam logic [1:0] RES_OFS  = 2'd3;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/fact_dp.sv
// Factorial datapath: down-counter, running product (32x4 multiply) and the
// result register that is only updated when a computation completes.
module fact_dp
  import fact_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  input  logic              finish,
  input  logic [N_W-1:0]    n,
  output logic              last,
  output logic [DATA_W-1:0] result
);

  logic [N_W-1:0]    cnt;
  logic [DATA_W-1:0] prod;
  logic [DATA_W-1:0] prod_next;

  // Only the low 32 bits of the product are kept; 12! still fits.
  assign prod_next = prod * {{(DATA_W-N_W){1'b0}}, cnt};
  assign last      = (cnt[N_W-1:1] == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      prod   <= DATA_W'(1);
      result <= '0;
    end else if (load) begin
      cnt  <= n;
      prod <= DATA_W'(1);
    end else if (step) begin
      cnt  <= cnt - N_W'(1);
      prod <= prod_next;
    end else if (finish) begin
      result <= prod;
    end
  end

endmodule

// File: rtl/fact_accel.sv
// Memory-mapped factorial accelerator: N/GO/STATUS/RESULT window, control FSM
// and combinational read mux around the fact_dp datapath.
module fact_accel
  import fact_pkg::*;
#(
  parameter int MAX_N = DEF_MAX_N
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        A,
  input  logic              WE,
  input  logic [DATA_W-1:0] WD,
  output logic [DATA_W-1:0] RD
);

  state_t            state_q, state_d;
  logic [N_W-1:0]    n_q;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              go, n_ok;
  logic              load, step, finish, last;
  logic [DATA_W-1:0] result;
  logic              unused_wd;

  assign unused_wd = ^WD[DATA_W-1:N_W];
  assign go        = WE && (A == GO_OFS) && WD[0];
  assign n_ok      = (int'(n_q) <= MAX_N);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      n_q     <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      err_q   <= err_d;
      if (WE && (A == N_OFS)) n_q <= WD[N_W-1:0];
    end
  end

  // GO is only honoured in IDLE; rejected starts leave the result untouched.
  always_comb begin
    state_d = state_q;
    done_d  = done_q;
    err_d   = err_q;
    load    = 1'b0;
    step    = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: begin
        if (go) begin
          done_d = 1'b0;
          if (n_ok) begin
            state_d = BUSY;
            load    = 1'b1;
            err_d   = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      BUSY: begin
        if (last) begin
          finish  = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          step = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  fact_dp u_dp (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (load),
    .step   (step),
    .finish (finish),
    .n      (n_q),
    .last   (last),
    .result (result)
  );

  always_comb begin
    RD = '0;
    case (A)
      N_OFS:    RD = {{(DATA_W-N_W){1'b0}}, n_q};
      GO_OFS:   RD = {{(DATA_W-1){1'b0}}, (state_q == BUSY)};
      STAT_OFS: RD = {{(DATA_W-2){1'b0}}, err_q, done_q};
      RES_OFS:  RD = result;
      default:  RD = '0;
    endcase
  end

endmodule

// File: tb/tb_fact_accel.sv
// Bench for fact_accel: register-level behavioural model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_fact_accel;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  a;
  logic        we;
  logic [31:0] wd;
  logic [31:0] rd;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Behavioural model state
  logic [3:0]  m_n      = '0;
  bit          m_busy   = 1'b0;
  bit          m_done   = 1'b0;
  bit          m_err    = 1'b0;
  logic [31:0] m_result = '0;
  logic [31:0] m_pend   = '0;
  int          m_left   = 0;

  fact_accel #(.MAX_N(12)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .A     (a),
    .WE    (we),
    .WD    (wd),
    .RD    (rd)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] fact(input int n);
    logic [31:0] r = 32'd1;
    for (int i = 2; i <= n; i++) r = r * i;
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_n <= '0; m_busy <= 1'b0; m_done <= 1'b0; m_err <= 1'b0;
      m_result <= '0; m_pend <= '0; m_left <= 0;
    end else begin
      if (we && a == 2'd0) m_n <= wd[3:0];
      if (m_busy) begin
        if (m_left <= 1) begin
          m_busy <= 1'b0; m_done <= 1'b1; m_result <= m_pend;
        end else begin
          m_left <= m_left - 1;
        end
      end else if (we && a == 2'd1 && wd[0]) begin
        m_done <= 1'b0;
        if (m_n > 12) begin
          m_err <= 1'b1;
        end else begin
          m_err  <= 1'b0;
          m_busy <= 1'b1;
          m_left <= (m_n == 0) ? 1 : int'(m_n);
          m_pend <= fact(int'(m_n));
        end
      end
    end
  end

  function automatic logic [31:0] model_rd(input logic [1:0] aa);
    case (aa)
      2'd0:    return {28'b0, m_n};
      2'd1:    return {31'b0, m_busy};
      2'd2:    return {30'b0, m_err, m_done};
      default: return m_result;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d (0x%08h) required=%0d (0x%08h)", name, act, act, exp, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) check($sformatf("model_rd_a%0d", a), rd, model_rd(a));
  end

  task automatic drive(input logic w, input logic [1:0] ad, input logic [31:0] d);
    @(posedge clk);
    #1;
    we = w; a = ad; wd = d;
  endtask

  task automatic peek(input logic [1:0] ad, input logic [31:0] exp, input string name);
    drive(1'b0, ad, 32'd0);
    @(negedge clk);
    check(name, rd, exp);
  endtask

  // Counts edges from the start edge until STATUS.done is seen, bounded.
  task automatic wait_done(input int lat, input string name);
    int e = 0;
    bit seen = 1'b0;
    while (!seen && e < 40) begin
      drive(1'b0, 2'd2, 32'd0);
      @(negedge clk);
      e++;
      seen = rd[0];
    end
    check(name, 32'(e - 1), 32'(lat));
  endtask

  task automatic start(input int n);
    drive(1'b1, 2'd0, 32'(n));
    drive(1'b1, 2'd1, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; we = 1'b0; a = 2'd0; wd = '0;
    cmp_en = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      a = 2'(i);
      #1;
      check($sformatf("reset_a%0d", i), rd, 32'd0);
    end

    // Release reset with GO already presented: N=0 start on the first edge
    @(posedge clk);
    #1;
    rst_n = 1'b1; we = 1'b1; a = 2'd1; wd = 32'd1;
    wait_done(1, "lat_n0");
    peek(2'd3, 32'd1, "res_n0");

    start(1);
    wait_done(1, "lat_n1");
    peek(2'd3, 32'd1, "res_n1");

    start(5);
    wait_done(5, "lat_n5");
    peek(2'd3, 32'd120, "res_n5");
    check("model_n5", m_result, 32'd120);
    peek(2'd2, 32'd1, "stat_n5");

    // Ignored writes: GO with bit0 clear, STATUS and RESULT offsets
    drive(1'b1, 2'd1, 32'd2);
    peek(2'd1, 32'd0, "go_bit0_clear");
    drive(1'b1, 2'd3, 32'hDEAD_BEEF);
    peek(2'd3, 32'd120, "res_write_ignored");
    drive(1'b1, 2'd2, 32'd2);
    peek(2'd2, 32'd1, "stat_write_ignored");

    start(12);
    wait_done(12, "lat_n12");
    peek(2'd3, 32'd479001600, "res_n12");
    check("model_n12", m_result, 32'h1C8C_FC00);

    start(13);
    peek(2'd2, 32'd2, "stat_n13_err");
    peek(2'd3, 32'd479001600, "res_n13_kept");
    peek(2'd1, 32'd0, "busy_n13");

    // N and GO written while busy must not disturb the run
    start(6);
    drive(1'b0, 2'd2, 32'd0);
    drive(1'b1, 2'd0, 32'd3);
    drive(1'b1, 2'd1, 32'd1);
    wait_done(3, "lat_n6_rest");
    peek(2'd3, 32'd720, "res_n6");
    peek(2'd0, 32'd3, "n_reads_3");

    // Abort mid-run via reset
    start(7);
    drive(1'b0, 2'd1, 32'd0);
    drive(1'b0, 2'd1, 32'd0);
    drive(1'b0, 2'd1, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b0; we = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      a = 2'(i);
      #1;
      check($sformatf("abort_a%0d", i), rd, 32'd0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    peek(2'd2, 32'd0, "done_after_abort");
    peek(2'd3, 32'd0, "res_after_abort");

    start(4);
    wait_done(4, "lat_n4");
    peek(2'd3, 32'd24, "res_n4");
    check("model_n4", m_result, 32'd24);

    drive(1'b0, 2'd0, 32'd0);
    @(negedge clk);
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
